// File: rtl/alu_pkg.sv
// Constants, encodings and helper predicates shared by the ALU-side divider.
package alu_pkg;

  localparam int unsigned WIDTH = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_FIX    = 2'd2;

  // Per-operation flags captured at START; operands themselves are not kept.
  typedef struct packed {
    logic is_rem;
    logic neg_quo;
    logic neg_rem;
    logic special;
  } div_ctrl_t;

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/divisor_seq_if.sv
// Request/result bundle between the pipeline and the sequential divider.
interface divisor_seq_if #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
);
  logic             START;
  logic [1:0]       OP;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] R;

  modport master (
    output START, OP, A, B,
    input  BUSY, DONE, R
  );

  modport slave (
    input  START, OP, A, B,
    output BUSY, DONE, R
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor on entry, so the trial always fits a WIDTH+1 signed result.
  assign shifted  = {rem, bit_in};
  assign trial    = shifted - {1'b0, divisor};
  assign q_bit    = ~trial[WIDTH];
  assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/divisor_seq.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
module divisor_seq #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input logic         CLK,
  input logic         RST_N,
  divisor_seq_if.slave bus
);
  import alu_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] r_q, r_d;
  div_ctrl_t        ctrl_q, ctrl_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             is_signed, is_rem, a_neg, b_neg, div_zero, sgn_ovf;
  logic [WIDTH-1:0] abs_a, abs_b, preload;
  logic [WIDTH-1:0] step_rem, quo_fix, rem_fix;
  logic             step_bit;

  // Operand conditioning and special-case detection for the IDLE capture.
  always_comb begin
    is_signed = op_is_signed(bus.OP);
    is_rem    = op_is_rem(bus.OP);
    a_neg     = is_signed & bus.A[WIDTH-1];
    b_neg     = is_signed & bus.B[WIDTH-1];
    abs_a     = a_neg ? (WIDTH'(0) - bus.A) : bus.A;
    abs_b     = b_neg ? (WIDTH'(0) - bus.B) : bus.B;
    div_zero  = (bus.B == '0);
    sgn_ovf   = is_signed & (bus.A == MIN_INT) & (bus.B == '1);
    if (div_zero) begin
      preload = is_rem ? bus.A : '1;
    end else begin
      preload = is_rem ? '0 : bus.A;
    end
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .bit_in   (quo_q[WIDTH-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .q_bit    (step_bit)
  );

  // Sign restoration applied in FIX: quotient by sign(A)^sign(B), remainder by sign(A).
  assign quo_fix = ctrl_q.neg_quo ? (WIDTH'(0) - quo_q) : quo_q;
  assign rem_fix = ctrl_q.neg_rem ? (WIDTH'(0) - rem_q) : rem_q;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    ctrl_d  = ctrl_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    r_d     = r_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          busy_d         = 1'b1;
          rem_d          = '0;
          dvs_d          = abs_b;
          cnt_d          = CNT_W'(WIDTH - 1);
          ctrl_d.is_rem  = is_rem;
          ctrl_d.neg_quo = a_neg ^ b_neg;
          ctrl_d.neg_rem = a_neg;
          if (div_zero || sgn_ovf) begin
            quo_d          = preload;
            ctrl_d.special = 1'b1;
            state_d        = ST_FIX;
          end else begin
            quo_d          = abs_a;
            ctrl_d.special = 1'b0;
            state_d        = ST_DIVIDE;
          end
        end
      end

      ST_DIVIDE: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_FIX: begin
        if (ctrl_q.special) begin
          r_d = quo_q;
        end else begin
          r_d = ctrl_q.is_rem ? rem_fix : quo_fix;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      ctrl_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_q     <= r_d;
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.R    = r_q;
endmodule

// File: tb/tb_divisor_seq.sv
// Self-checking bench for divisor_seq: directed vectors, corner sequences, random ops.
module tb_divisor_seq;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  divisor_seq_if #(.WIDTH(W)) bus ();

  divisor_seq #(.WIDTH(W)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // RISC-V division semantics straight from the ISA rules.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat);
    lat = 33;
    if (b == 32'd0) begin
      lat = 1;
      r = (op == OP_REM || op == OP_REMU) ? a : 32'hFFFF_FFFF;
    end else if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lat = 1;
      r = (op == OP_REM) ? 32'd0 : 32'h8000_0000;
    end else begin
      case (op)
        OP_DIV:  r = 32'($signed(a) / $signed(b));
        OP_REM:  r = 32'($signed(a) % $signed(b));
        OP_DIVU: r = a / b;
        default: r = a % b;
      endcase
    end
  endtask

  // Issue one op from the current point (just after a rising edge); return R and DONE latency.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int glitch, output logic [31:0] r, output int lat);
    bus.START = 1'b1;
    bus.OP    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk); #1;
    bus.START = 1'b0;
    bus.OP    = 2'($urandom);
    bus.A     = $urandom;
    bus.B     = $urandom;
    check("busy_after_accept", 32'(bus.BUSY), 32'd1);
    check("done_low_after_accept", 32'(bus.DONE), 32'd0);
    lat = 0;
    while (!bus.DONE && lat < 100) begin
      if (lat == glitch) begin
        bus.START = 1'b1;
        bus.OP    = OP_DIV;
        bus.A     = 32'd999;
        bus.B     = 32'd3;
      end else begin
        bus.START = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.START = 1'b0;
    r = bus.R;
    check("busy_low_in_done", 32'(bus.BUSY), 32'd0);
  endtask

  initial begin
    logic [31:0] r, exp_r, last_r;
    int          lat, exp_lat;
    logic        seen;

    vecs[0]  = '{OP_DIV,  32'd40,        32'd21,        32'd1,         33};
    vecs[1]  = '{OP_REM,  32'd40,        32'd21,        32'd19,        33};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFE7, 32'd20,        32'hFFFF_FFFF, 33};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFE7, 32'd20,        32'hFFFF_FFFB, 33};
    vecs[4]  = '{OP_DIVU, 32'hFFFF_FFE7, 32'd20,        32'h0CCC_CCCB, 33};
    vecs[5]  = '{OP_REMU, 32'hFFFF_FFE7, 32'd20,        32'h0000_000B, 33};
    vecs[6]  = '{OP_DIV,  32'd20,        32'd0,         32'hFFFF_FFFF, 1};
    vecs[7]  = '{OP_REM,  32'd20,        32'd0,         32'h0000_0014, 1};
    vecs[8]  = '{OP_DIVU, 32'd20,        32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{OP_REMU, 32'd20,        32'd0,         32'h0000_0014, 1};
    vecs[10] = '{OP_DIV,  32'd20,        32'd20,        32'd1,         33};
    vecs[11] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[12] = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[13] = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};

    bus.START = 1'b0;
    bus.OP    = 2'b00;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(bus.BUSY), 32'd0);
    check("reset_done", 32'(bus.DONE), 32'd0);
    check("reset_r", bus.R, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, r, lat);
      check($sformatf("vec%0d_r", i), r, vecs[i].r);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_single", i), 32'(bus.DONE), 32'd0);
    end

    // START pulsed mid-operation is ignored.
    run_op(OP_DIV, 32'd100, 32'd7, 5, r, lat);
    check("ignored_start_r", r, 32'd14);
    check("ignored_start_latency", 32'(lat), 32'd33);
    @(posedge clk); #1;
    check("ignored_start_no_extra_busy", 32'(bus.BUSY), 32'd0);

    // 40 idle cycles, then an op chained directly on the DONE cycle.
    repeat (40) @(posedge clk);
    #1;
    run_op(OP_REMU, 32'd1000, 32'd7, -1, r, lat);
    check("idle40_r", r, 32'd6);
    run_op(OP_DIV, 32'd40, 32'd21, -1, r, lat);
    check("chained_r", r, 32'd1);
    check("chained_latency", 32'(lat), 32'd33);

    // Reset asserted ten cycles into a DIV.
    bus.START = 1'b1;
    bus.OP    = OP_DIV;
    bus.A     = 32'd1000;
    bus.B     = 32'd3;
    @(posedge clk); #1;
    bus.START = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midop_reset_busy", 32'(bus.BUSY), 32'd0);
    check("midop_reset_done", 32'(bus.DONE), 32'd0);
    check("midop_reset_r", bus.R, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.DONE || bus.BUSY) seen = 1'b1;
    end
    check("no_done_after_reset", 32'(seen), 32'd0);
    check("r_zero_after_reset", bus.R, 32'd0);
    run_op(OP_REM, 32'hFFFF_FFE7, 32'd20, -1, r, lat);
    check("after_reset_r", r, 32'hFFFF_FFFB);
    check("after_reset_latency", 32'(lat), 32'd33);

    // Randomized ops against the arithmetic model.
    for (int k = 0; k < 200; k++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 16));
        3: b = a;
        4: a = 32'($urandom_range(0, 50));
        default: ;
      endcase
      model(op, a, b, exp_r, exp_lat);
      run_op(op, a, b, -1, r, lat);
      check($sformatf("rand%0d_r op=%0d a=%h b=%h", k, op, a, b), r, exp_r);
      check($sformatf("rand%0d_latency", k), 32'(lat), 32'(exp_lat));
      last_r = r;
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        check($sformatf("rand%0d_r_held", k), bus.R, last_r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/divisor_seq.md
# divisor_seq

Multi-cycle restoring divider for the RV32M `DIV`/`DIVU`/`REM`/`REMU` instructions, sitting next to the combinational ALU and sharing its `A`/`B` operand buses. The ALU subtractor's trial-subtract is reused one bit per cycle, so area stays small. The block accepts an operation on a one-cycle `START` strobe and holds `BUSY` while iterating. It returns a registered result `R` with a one-cycle `DONE` pulse for the pipeline stall logic.

## Interface

Parameters:
- `WIDTH`, default 32: operand and result width; the iteration count equals `WIDTH`.

Ports:
- `CLK`  in  1  one clock; reset is asynchronous and active-low.
- `RST_N`  in  1  asynchronous, active-low reset.
- `START`  in  1  request strobe; sampled only in IDLE.
- `OP`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- `A`  in  WIDTH  dividend.
- `B`  in  WIDTH  divisor.
- `BUSY`  out  1  high from the edge accepting `START` until the edge that raises `DONE`.
- `DONE`  out  1  one-cycle pulse; `R` is valid in this cycle.
- `R`  out  WIDTH  quotient or remainder; held until the next `DONE`.

## Operation

- States:
  - IDLE: waiting for `START`.
  - DIVIDE: one iteration per cycle; counter runs WIDTH-1 down to 0.
  - FIX: sign correction, `R` load, `DONE`.
- IDLE, `START`=1:
  - Capture `OP`, the signs of `A`/`B` (signed ops only) and |A|, |B|.
  - Clear the remainder register.
  - Go to DIVIDE.
  - Special cases bypass DIVIDE: a preloaded result is produced and the state goes straight to FIX.
- DIVIDE iteration:
  - Shift {rem, quo} left by one, bringing in the dividend MSB.
  - Trial = rem − |B|, computed WIDTH+1 bits wide.
  - Trial non-negative: rem = trial, quotient bit 1. Otherwise rem unchanged, quotient bit 0.
  - After the counter-0 iteration, go to FIX.
- FIX:
  - Signed quotient is negated if sign(A) ≠ sign(B).
  - Signed remainder takes sign(A).
  - Load `R`, pulse `DONE`, return to IDLE.
- Special cases (RISC-V semantics, no trap):
  - B = 0: DIV/DIVU → all ones; REM/REMU → A.
  - Signed overflow, A = 0x80000000 and B = 0xFFFFFFFF: DIV → 0x80000000; REM → 0.
- `START` while BUSY: ignored; no queuing.
- `A`/`B`/`OP` may change freely after the accepting edge.
- Reset, at any time including mid-operation:
  - State IDLE, counter 0, `BUSY`=0, `DONE`=0, `R`=0.
  - The pending operation is discarded and no `DONE` is produced.

## Timing

- Edge k accepts `START`.
- Normal path: edges k+1 … k+WIDTH iterate; edge k+WIDTH+1 performs FIX. `DONE`=1 and `R` valid in the cycle after edge k+33 (WIDTH = 32).
- Special path: edge k+1 performs FIX; `DONE` in the cycle after edge k+1.
- `BUSY` rises after edge k and falls on the same edge that raises `DONE`.
- A new `START` is accepted in the `DONE` cycle itself, since the state is already IDLE.
- `DONE` is never high for two consecutive cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure

- Shared package `alu_pkg`:
  - `WIDTH` constant.
  - OP encodings `OP_DIV`, `OP_DIVU`, `OP_REM`, `OP_REMU`.
  - State encoding IDLE/DIVIDE/FIX.
- Sub-module `div_step`: combinational single restoring step.
  - Inputs: rem, next dividend bit, divisor.
  - Outputs: new rem, quotient bit.
  - Built on the existing subtractor formulation, widened to WIDTH+1 bits.
- Top level holds the FSM, counter, abs/negate logic and the special-case detector.

## Test plan

- DIV then REM, A=40, B=21 → `R`=1, then `R`=19; `DONE` exactly 33 cycles after each `START` edge.
- A=0xFFFFFFE7 (−25), B=20:
  - DIV → 0xFFFFFFFF.
  - REM → 0xFFFFFFFB.
  - DIVU → 0x0CCCCCCB.
  - REMU → 0x0000000B.
- A=20, B=0 → DIV 0xFFFFFFFF, REM 0x00000014; A=20, B=20, DIV → 1, `DONE` 33 cycles after `START`. Divide-by-zero `DONE` arrives 1 cycle after `START`.
- A=0x80000000, B=0xFFFFFFFF → DIV 0x80000000, REM 0; DIVU → 0; `DONE` 1 cycle after `START` for DIV/REM.
- `START` pulsed again at cycle 5 with different operands → ignored; the first result is unaffected.
- `START` at cycle 40 of an IDLE period chained on the `DONE` cycle → accepted.
- `RST_N` asserted at cycle 10 of a DIV → `BUSY`/`DONE`/`R` 0 immediately, no later `DONE`; next op completes normally.
